// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin share of the register_file write port plus a pending-write scoreboard
// Ports:
//   i_clk         system clock, all state on rising edge
//   i_rst_n       synchronous active-low reset
//   i_req_valid   per-requester writeback pending
//   o_req_ready   one-hot grant, gated low while in reset
//   i_req_rd      packed dest regs, requester i at [i*AW +: AW]
//   i_req_data    packed write data, requester i at [i*XLEN +: XLEN]
//   i_mark_valid  reserve i_mark_rd for a future write
//   i_mark_rd     register being reserved
//   o_rf_we       register_file write enable
//   o_rf_rd       register_file destination
//   o_rf_data_in  register_file write data
//   o_busy_mask   bit r set while register r has a reserved, uncommitted write
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int AW      = 5
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*AW-1:0]   i_req_rd,
    input  logic [NUM_REQ*XLEN-1:0] i_req_data,
    input  logic                    i_mark_valid,
    input  logic [AW-1:0]           i_mark_rd,
    output logic                    o_rf_we,
    output logic [AW-1:0]           o_rf_rd,
    output logic [XLEN-1:0]         o_rf_data_in,
    output logic [31:0]             o_busy_mask
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    logic [PW-1:0]   r_rr_ptr;
    logic            r_we;
    logic [AW-1:0]   r_rd;
    logic [XLEN-1:0] r_data;
    logic [31:0]     r_busy;
    logic [PW-1:0]   w_gnt_idx;
    logic            w_any;
    logic            w_fire;
    logic [AW-1:0]   w_rd_arr [NUM_REQ];
    logic [XLEN-1:0] w_data_arr [NUM_REQ];
    logic [AW-1:0]   w_rd;
    logic [XLEN-1:0] w_data;
    logic [31:0]     w_set;
    logic [31:0]     w_clr;
    logic [31:0]     w_busy_nxt;
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_rd_arr[g]   = i_req_rd[g*AW +: AW];
        assign w_data_arr[g] = i_req_data[g*XLEN +: XLEN];
    end
    // Scan from the highest offset down so the lowest offset from r_rr_ptr is the last to win.
    always_comb begin
        w_any     = 1'b0;
        w_gnt_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (i_req_valid[PW'((int'(r_rr_ptr) + k) % NUM_REQ)]) begin
                w_any     = 1'b1;
                w_gnt_idx = PW'((int'(r_rr_ptr) + k) % NUM_REQ);
            end
        end
    end
    assign w_fire      = w_any && i_rst_n;
    assign o_req_ready = w_fire ? NUM_REQ'(1) << w_gnt_idx : '0;
    assign w_rd        = w_rd_arr[w_gnt_idx];
    assign w_data      = w_data_arr[w_gnt_idx];
    // Clear happens before set so a re-reservation in the commit cycle survives; bit 0 never sets.
    assign w_clr      = r_we ? 32'd1 << r_rd : '0;
    assign w_set      = (i_mark_valid && i_mark_rd != '0) ? 32'd1 << i_mark_rd : '0;
    assign w_busy_nxt = ((r_busy & ~w_clr) | w_set) & ~32'd1;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
            r_we     <= 1'b0;
            r_rd     <= '0;
            r_data   <= '0;
            r_busy   <= '0;
        end else begin
            r_we   <= w_fire && w_rd != '0;
            r_busy <= w_busy_nxt;
            if (w_fire) begin
                r_rd     <= w_rd;
                r_data   <= w_data;
                r_rr_ptr <= w_gnt_idx == PW'(NUM_REQ - 1) ? '0 : w_gnt_idx + 1'b1;
            end
        end
    end
    assign o_rf_we      = r_we;
    assign o_rf_rd      = r_rd;
    assign o_rf_data_in = r_data;
    assign o_busy_mask  = r_busy;
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed and randomized check of regfile_wb_arbiter against a behavioural model
module tb_regfile_wb_arbiter;
    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int AW      = 5;
    logic                    clk;
    logic                    rst_n;
    logic [NUM_REQ-1:0]      valid;
    logic [NUM_REQ-1:0]      ready;
    logic [NUM_REQ*AW-1:0]   req_rd;
    logic [NUM_REQ*XLEN-1:0] req_data;
    logic                    mark;
    logic [AW-1:0]           mrd;
    logic                    rf_we;
    logic [AW-1:0]           rf_rd;
    logic [XLEN-1:0]         rf_data;
    logic [31:0]             busy;
    logic [AW-1:0]           rd_a [NUM_REQ];
    logic [XLEN-1:0]         data_a [NUM_REQ];
    int                      n_vec;
    int                      n_err;
    int                      m_ptr;
    logic                    m_we;
    logic [AW-1:0]           m_rd;
    logic [XLEN-1:0]         m_data;
    logic [31:0]             m_busy;
    regfile_wb_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .AW(AW)) dut (
        .i_clk(clk),
        .i_rst_n(rst_n),
        .i_req_valid(valid),
        .o_req_ready(ready),
        .i_req_rd(req_rd),
        .i_req_data(req_data),
        .i_mark_valid(mark),
        .i_mark_rd(mrd),
        .o_rf_we(rf_we),
        .o_rf_rd(rf_rd),
        .o_rf_data_in(rf_data),
        .o_busy_mask(busy)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            req_rd[i*AW +: AW]       = rd_a[i];
            req_data[i*XLEN +: XLEN] = data_a[i];
        end
    end
    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask
    // One clock: check the combinational grant, clock it, then check the registered state.
    task automatic step();
        int g;
        logic [NUM_REQ-1:0] exp_rdy;
        g = -1;
        if (rst_n)
            for (int k = NUM_REQ - 1; k >= 0; k--)
                if (valid[(m_ptr + k) % NUM_REQ]) g = (m_ptr + k) % NUM_REQ;
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        #1 chk("ready", 64'(ready), 64'(exp_rdy));
        @(posedge clk);
        if (!rst_n) begin
            m_we = 0; m_rd = 0; m_data = 0; m_busy = 0; m_ptr = 0;
        end else begin
            if (m_we) m_busy[m_rd] = 1'b0;
            if (mark && mrd != 0) m_busy[mrd] = 1'b1;
            m_we = g >= 0 && rd_a[g] != 0;
            if (g >= 0) begin
                m_rd   = rd_a[g];
                m_data = data_a[g];
                m_ptr  = (g + 1) % NUM_REQ;
            end
        end
        @(negedge clk);
        if (g >= 0) valid[g] = 1'b0;
        mark = 1'b0;
        chk("rf_we", 64'(rf_we), 64'(m_we));
        chk("rf_rd", 64'(rf_rd), 64'(m_rd));
        chk("rf_data", 64'(rf_data), 64'(m_data));
        chk("busy", 64'(busy), 64'(m_busy));
    endtask
    initial begin
        n_vec = 0; n_err = 0;
        m_ptr = 0; m_we = 0; m_rd = 0; m_data = 0; m_busy = 0;
        rst_n = 1'b0; valid = '1; mark = 1'b0; mrd = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rd_a[i] = AW'(i + 1);
            data_a[i] = 32'hA000_0000 + i;
        end
        @(negedge clk);
        step();
        valid = '1;
        step();
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        valid = 3'b010; rd_a[1] = 5'd7; data_a[1] = 32'h0000_1FE5;
        #1 chk("single_ready", 64'(ready), 64'b010);
        step();
        chk("single_we", 64'(rf_we), 64'd1);
        chk("single_rd", 64'(rf_rd), 64'd7);
        chk("single_data", 64'(rf_data), 64'h1FE5);
        valid = 3'b100; rd_a[2] = 5'd0; data_a[2] = 32'hDEAD_BEEF;
        #1 chk("x0_ready", 64'(ready), 64'b100);
        step();
        chk("x0_we", 64'(rf_we), 64'd0);
        valid = '1; rd_a[2] = 5'd9;
        #1 chk("x0_ptr_adv", 64'(ready), 64'b001);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            valid = '1;
            #1 chk("rr_order", 64'(ready), 64'(1 << (c % 3)));
            step();
            chk("rr_we", 64'(rf_we), 64'd1);
        end
        valid = '0; mark = 1'b1; mrd = 5'd12;
        step();
        chk("mark12", 64'(busy[12]), 64'd1);
        valid = 3'b001; rd_a[0] = 5'd12; data_a[0] = 32'h1234_5678;
        step();
        step();
        chk("commit12", 64'(busy[12]), 64'd0);
        mark = 1'b1; mrd = 5'd12;
        step();
        valid = 3'b001;
        step();
        mark = 1'b1; mrd = 5'd12;
        step();
        chk("set_wins12", 64'(busy[12]), 64'd1);
        mark = 1'b1; mrd = 5'd20;
        step();
        valid = 3'b010; rd_a[1] = 5'd5; data_a[1] = 32'h5555_0005;
        step();
        chk("pre_rst_we", 64'(rf_we), 64'd1);
        rst_n = 1'b0; valid = 3'b100;
        step();
        chk("mid_rst_we", 64'(rf_we), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1; valid = '1;
        #1 chk("mid_rst_ptr", 64'(ready), 64'b001);
        step();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++)
                if (!valid[i] && $urandom_range(0, 99) < 55) begin
                    valid[i]  = 1'b1;
                    rd_a[i]   = $urandom_range(0, 7) == 0 ? 5'd0 : AW'($urandom);
                    data_a[i] = $urandom;
                end
            mark  = $urandom_range(0, 99) < 35;
            mrd   = AW'($urandom);
            rst_n = $urandom_range(0, 99) >= 2;
            step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
